// File: rtl/sump_cmd_decoder_pkg.sv
// sump_cmd_pkg: opcode constants, FSM state type and stage limit shared by SUMP command consumers
package sump_cmd_pkg;
  localparam int MAX_STAGES = 4;
  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_ARM       = 8'h01;
  localparam logic [7:0] OP_ID        = 8'h02;
  localparam logic [7:0] OP_META      = 8'h04;
  localparam logic [7:0] OP_FINISH    = 8'h06;
  localparam logic [7:0] OP_XON       = 8'h11;
  localparam logic [7:0] OP_XOFF      = 8'h13;
  localparam logic [7:0] OP_DIV       = 8'h80;
  localparam logic [7:0] OP_COUNT     = 8'h81;
  localparam logic [7:0] OP_FLAGS     = 8'h82;
  localparam logic [7:0] OP_TRIG_BASE = 8'hC0;
  typedef enum logic {IDLE, ARMED} state_t;
endpackage

// File: rtl/sump_cmd_decoder_if.sv
// sump_cmd_decoder_if: command word in, decoded configuration and strobes out
interface sump_cmd_decoder_if #(parameter int STAGES = 4);
  logic [39:0]       cmd;
  logic              execute;
  logic              captureDone;
  logic              softReset;
  logic              arm;
  logic              armed;
  logic              xoff;
  logic [23:0]       divider;
  logic [17:0]       readCount;
  logic [17:0]       delayCount;
  logic [15:0]       flags;
  logic              wrDivider;
  logic              wrCount;
  logic              wrFlags;
  logic [STAGES-1:0] wrTrigMask;
  logic [STAGES-1:0] wrTrigValue;
  logic [STAGES-1:0] wrTrigCfg;
  logic [31:0]       trigData;
  logic              badCmd;
  modport master (
    output cmd, execute, captureDone,
    input  softReset, arm, armed, xoff, divider, readCount, delayCount, flags,
           wrDivider, wrCount, wrFlags, wrTrigMask, wrTrigValue, wrTrigCfg, trigData, badCmd
  );
  modport slave (
    input  cmd, execute, captureDone,
    output softReset, arm, armed, xoff, divider, readCount, delayCount, flags,
           wrDivider, wrCount, wrFlags, wrTrigMask, wrTrigValue, wrTrigCfg, trigData, badCmd
  );
endinterface

// File: rtl/sump_cmd_decoder_edge_detect.sv
// cmd_edge_detect: registered rising-edge detector; after reset the level must be seen low before an edge counts
module cmd_edge_detect (
  input  logic clock,
  input  logic extReset_n,
  input  logic level,
  output logic rise
);
  logic level_d, primed;
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      level_d <= 1'b0;
      primed  <= 1'b0;
    end else begin
      level_d <= level;
      primed  <= primed | ~level;
    end
  end
  assign rise = level & ~level_d & primed;
endmodule

// File: rtl/sump_cmd_decoder.sv
// sump_cmd_decoder: decodes SUMP commands into config registers, strobes and arm FSM
// Optional SUMP_RESET_COUNT_EN: softReset only on the 5th consecutive 0x00 command.
module sump_cmd_decoder
  import sump_cmd_pkg::*;
#(
  parameter int STAGES = MAX_STAGES
) (
  input  logic                clock,
  input  logic                extReset_n,
  sump_cmd_decoder_if.slave   cmd_bus
);
  logic              cmd_valid, do_reset, is_trig, known;
  logic [7:0]        opcode;
  logic [31:0]       opdata;
  logic [1:0]        stage, kind;
  logic [STAGES-1:0] stage_hot;
  state_t            state, state_nxt;
  cmd_edge_detect u_edge (
    .clock      (clock),
    .extReset_n (extReset_n),
    .level      (cmd_bus.execute),
    .rise       (cmd_valid)
  );
  assign opcode     = cmd_bus.cmd[7:0];
  assign opdata     = cmd_bus.cmd[39:8];
  assign stage      = opcode[3:2];
  assign kind       = opcode[1:0];
  assign stage_hot  = STAGES'(1) << stage;
  assign is_trig    = opcode[7:4] == OP_TRIG_BASE[7:4] && kind != 2'd3 && int'(stage) < STAGES;
  assign known      = is_trig || opcode inside {OP_RESET, OP_ARM, OP_ID, OP_META, OP_FINISH,
                                                OP_XON, OP_XOFF, OP_DIV, OP_COUNT, OP_FLAGS};
`ifdef SUMP_RESET_COUNT_EN
  logic [2:0] rst_cnt;
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) rst_cnt <= '0;
    else if (cmd_valid) rst_cnt <= (opcode != OP_RESET || rst_cnt == 3'd4) ? 3'd0 : rst_cnt + 3'd1;
  end
  assign do_reset = cmd_valid && opcode == OP_RESET && rst_cnt == 3'd4;
`else
  assign do_reset = cmd_valid && opcode == OP_RESET;
`endif
  // A fresh arm beats a coincident captureDone
  assign state_nxt = (cmd_valid && opcode == OP_ARM) ? ARMED :
                     (do_reset || cmd_bus.captureDone) ? IDLE : state;
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      state               <= IDLE;
      cmd_bus.armed       <= 1'b0;
      cmd_bus.softReset   <= 1'b0;
      cmd_bus.arm         <= 1'b0;
      cmd_bus.badCmd      <= 1'b0;
      cmd_bus.wrDivider   <= 1'b0;
      cmd_bus.wrCount     <= 1'b0;
      cmd_bus.wrFlags     <= 1'b0;
      cmd_bus.wrTrigMask  <= '0;
      cmd_bus.wrTrigValue <= '0;
      cmd_bus.wrTrigCfg   <= '0;
      cmd_bus.xoff        <= 1'b0;
      cmd_bus.divider     <= '0;
      cmd_bus.readCount   <= '0;
      cmd_bus.delayCount  <= '0;
      cmd_bus.flags       <= '0;
      cmd_bus.trigData    <= '0;
    end else begin
      state               <= state_nxt;
      cmd_bus.armed       <= state_nxt == ARMED;
      cmd_bus.softReset   <= do_reset;
      cmd_bus.arm         <= cmd_valid && opcode == OP_ARM;
      cmd_bus.badCmd      <= cmd_valid && !known;
      cmd_bus.wrDivider   <= cmd_valid && opcode == OP_DIV;
      cmd_bus.wrCount     <= cmd_valid && opcode == OP_COUNT;
      cmd_bus.wrFlags     <= cmd_valid && opcode == OP_FLAGS;
      cmd_bus.wrTrigMask  <= (cmd_valid && is_trig && kind == 2'd0) ? stage_hot : '0;
      cmd_bus.wrTrigValue <= (cmd_valid && is_trig && kind == 2'd1) ? stage_hot : '0;
      cmd_bus.wrTrigCfg   <= (cmd_valid && is_trig && kind == 2'd2) ? stage_hot : '0;
      if (do_reset) begin
        cmd_bus.xoff       <= 1'b0;
        cmd_bus.divider    <= '0;
        cmd_bus.readCount  <= '0;
        cmd_bus.delayCount <= '0;
        cmd_bus.flags      <= '0;
        cmd_bus.trigData   <= '0;
      end else if (cmd_valid) begin
        if (opcode == OP_XOFF) cmd_bus.xoff <= 1'b1;
        if (opcode == OP_XON) cmd_bus.xoff <= 1'b0;
        if (opcode == OP_DIV) cmd_bus.divider <= opdata[23:0];
        if (opcode == OP_COUNT) cmd_bus.readCount <= {opdata[15:0], 2'b00} + 18'd4;
        if (opcode == OP_COUNT) cmd_bus.delayCount <= {opdata[31:16], 2'b00} + 18'd4;
        if (opcode == OP_FLAGS) cmd_bus.flags <= opdata[15:0];
        if (is_trig) cmd_bus.trigData <= opdata;
      end
    end
  end
endmodule

// File: tb/tb_sump_cmd_decoder.sv
// tb_sump_cmd_decoder: random + directed commands checked every cycle against a behavioural model
module tb_sump_cmd_decoder;
  localparam int STAGES = 4;
  logic clock = 1'b0;
  logic extReset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bit cd_rand = 1'b0;
  sump_cmd_decoder_if #(.STAGES(STAGES)) cmd_bus ();
  sump_cmd_decoder #(.STAGES(STAGES)) dut (
    .clock      (clock),
    .extReset_n (extReset_n),
    .cmd_bus    (cmd_bus)
  );
  always #5 clock = ~clock;

  logic [23:0] m_div = '0;
  logic [17:0] m_rc = '0, m_dc = '0;
  logic [15:0] m_flags = '0;
  logic [31:0] m_trig = '0;
  bit m_xoff, m_armed, m_prev;
  int m_zeros;
  bit e_soft, e_arm, e_bad, e_div, e_cnt, e_flg;
  logic [STAGES-1:0] e_mask = '0, e_val = '0, e_cfg = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_strobes();
    {e_soft, e_arm, e_bad, e_div, e_cnt, e_flg} = '0;
    e_mask = '0;
    e_val = '0;
    e_cfg = '0;
  endtask

  task automatic model_cmd(input logic [7:0] op, input logic [31:0] d, output bit armed_now);
    int idx;
    armed_now = 1'b0;
    if (op != 8'h00) m_zeros = 0;
    if (op == 8'h00) begin
`ifdef SUMP_RESET_COUNT_EN
      m_zeros++;
      if (m_zeros < 5) return;
      m_zeros = 0;
`endif
      e_soft = 1'b1;
      m_div = '0; m_rc = '0; m_dc = '0; m_flags = '0; m_xoff = 1'b0; m_trig = '0; m_armed = 1'b0;
    end else if (op == 8'h01) begin
      e_arm = 1'b1; m_armed = 1'b1; armed_now = 1'b1;
    end else if (op == 8'h11) m_xoff = 1'b0;
    else if (op == 8'h13) m_xoff = 1'b1;
    else if (op inside {8'h02, 8'h04, 8'h06}) ;
    else if (op == 8'h80) begin
      m_div = d[23:0]; e_div = 1'b1;
    end else if (op == 8'h81) begin
      m_rc = 18'((int'(d[15:0]) * 4 + 4) % 262144);
      m_dc = 18'((int'(d[31:16]) * 4 + 4) % 262144);
      e_cnt = 1'b1;
    end else if (op == 8'h82) begin
      m_flags = d[15:0]; e_flg = 1'b1;
    end else if (op inside {[8'hC0:8'hCF]}) begin
      idx = int'(op) - 192;
      if (idx % 4 != 3 && idx / 4 < STAGES) begin
        if (idx % 4 == 0) e_mask[idx/4] = 1'b1;
        if (idx % 4 == 1) e_val[idx/4] = 1'b1;
        if (idx % 4 == 2) e_cfg[idx/4] = 1'b1;
        m_trig = d;
      end else e_bad = 1'b1;
    end else e_bad = 1'b1;
  endtask

  // Behavioural reference: execute is treated as high throughout reset, so only a fresh rise counts
  always @(posedge clock or negedge extReset_n) begin
    bit an;
    if (!extReset_n) begin
      clear_strobes();
      m_div = '0; m_rc = '0; m_dc = '0; m_flags = '0; m_trig = '0;
      m_xoff = 1'b0; m_armed = 1'b0; m_prev = 1'b1; m_zeros = 0;
    end else begin
      clear_strobes();
      an = 1'b0;
      if (cmd_bus.execute && !m_prev) model_cmd(cmd_bus.cmd[7:0], cmd_bus.cmd[39:8], an);
      if (cmd_bus.captureDone && !an) m_armed = 1'b0;
      m_prev = cmd_bus.execute;
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    chk("softReset", cmd_bus.softReset, e_soft);
    chk("arm", cmd_bus.arm, e_arm);
    chk("armed", cmd_bus.armed, m_armed);
    chk("xoff", cmd_bus.xoff, m_xoff);
    chk("divider", cmd_bus.divider, m_div);
    chk("readCount", cmd_bus.readCount, m_rc);
    chk("delayCount", cmd_bus.delayCount, m_dc);
    chk("flags", cmd_bus.flags, m_flags);
    chk("wrDivider", cmd_bus.wrDivider, e_div);
    chk("wrCount", cmd_bus.wrCount, e_cnt);
    chk("wrFlags", cmd_bus.wrFlags, e_flg);
    chk("wrTrigMask", cmd_bus.wrTrigMask, e_mask);
    chk("wrTrigValue", cmd_bus.wrTrigValue, e_val);
    chk("wrTrigCfg", cmd_bus.wrTrigCfg, e_cfg);
    chk("trigData", cmd_bus.trigData, m_trig);
    chk("badCmd", cmd_bus.badCmd, e_bad);
  end

  task automatic tick();
    @(negedge clock);
    cmd_bus.captureDone = cd_rand && ($urandom_range(7) == 0);
  endtask

  task automatic start(input logic [7:0] op, input logic [31:0] d);
    tick();
    cmd_bus.cmd = {d, op};
    cmd_bus.execute = 1'b1;
  endtask

  task automatic stop();
    tick();
    cmd_bus.execute = 1'b0;
  endtask

  task automatic sample();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int h;
    logic [7:0] op;
    cmd_bus.cmd = '0;
    cmd_bus.execute = 1'b0;
    cmd_bus.captureDone = 1'b0;
    repeat (3) tick();
    chk("reset divider", cmd_bus.divider, 24'h0);
    chk("reset armed", cmd_bus.armed, 1'b0);
    extReset_n = 1'b1;
    repeat (2) tick();
    start(8'h80, 32'h0000_1234);
    sample();
    chk("lit wrDivider N+1", cmd_bus.wrDivider, 1'b1);
    chk("lit divider", cmd_bus.divider, 24'h001234);
    sample();
    chk("lit wrDivider width", cmd_bus.wrDivider, 1'b0);
    repeat (8) tick();
    stop();
    start(8'h81, 32'h0003_FFFF);
    sample();
    chk("lit readCount wrap", cmd_bus.readCount, 18'h00000);
    chk("lit delayCount", cmd_bus.delayCount, 18'h00010);
    chk("lit wrCount", cmd_bus.wrCount, 1'b1);
    stop();
    start(8'hC5, 32'hA5A5_A5A5);
    sample();
    chk("lit wrTrigValue", cmd_bus.wrTrigValue, 4'b0010);
    chk("lit trigData", cmd_bus.trigData, 32'hA5A5_A5A5);
    stop();
    start(8'hC3, 32'h1111_1111);
    sample();
    chk("lit badCmd C3", cmd_bus.badCmd, 1'b1);
    chk("lit no trig C3", {cmd_bus.wrTrigMask, cmd_bus.wrTrigValue, cmd_bus.wrTrigCfg}, 12'h0);
    stop();
    start(8'h04, 32'h0);
    sample();
    chk("lit no bad 04", cmd_bus.badCmd, 1'b0);
    stop();
    start(8'h01, 32'h0);
    sample();
    chk("lit arm", cmd_bus.arm, 1'b1);
    chk("lit armed", cmd_bus.armed, 1'b1);
    stop();
    start(8'h01, 32'h0);
    cmd_bus.captureDone = 1'b1;
    sample();
    chk("lit armed cd+arm", cmd_bus.armed, 1'b1);
    stop();
    tick();
    cmd_bus.captureDone = 1'b1;
    sample();
    chk("lit armed cd", cmd_bus.armed, 1'b0);
    tick();
    start(8'h82, 32'h0000_BEEF);
    sample();
    chk("lit flags", cmd_bus.flags, 16'hBEEF);
    stop();
`ifdef SUMP_RESET_COUNT_EN
    repeat (4) begin
      start(8'h00, 32'h0); sample(); chk("lit no softReset", cmd_bus.softReset, 1'b0); stop();
    end
    start(8'h82, 32'h0000_1234); sample(); stop();
    repeat (4) begin
      start(8'h00, 32'h0); sample(); chk("lit no softReset", cmd_bus.softReset, 1'b0); stop();
    end
`endif
    start(8'h00, 32'h0);
    sample();
    chk("lit softReset", cmd_bus.softReset, 1'b1);
    chk("lit flags cleared", cmd_bus.flags, 16'h0);
    stop();
    start(8'h80, 32'h00AB_CDEF);
    sample();
    tick();
    #2 extReset_n = 1'b0;
    #1 chk("lit async divider", cmd_bus.divider, 24'h0);
    repeat (2) tick();
    extReset_n = 1'b1;
    repeat (3) begin
      sample();
      chk("lit held no strobe", cmd_bus.wrDivider, 1'b0);
    end
    stop();
    start(8'h80, 32'h0000_0055);
    sample();
    chk("lit fresh edge", cmd_bus.divider, 24'h000055);
    stop();
    cd_rand = 1'b1;
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 9))
        0: op = 8'h00;
        1: op = 8'h01;
        2: op = $urandom_range(1) ? 8'h11 : 8'h13;
        3: op = 8'h02 + 8'($urandom_range(0, 2) * 2);
        4: op = 8'h80;
        5: op = 8'h81;
        6: op = 8'h82;
        7, 8: op = 8'hC0 + 8'($urandom_range(0, 15));
        default: op = 8'($urandom_range(0, 255));
      endcase
      start(op, $urandom);
      h = $urandom_range(1, 3);
      repeat (h - 1) begin
        tick();
        cmd_bus.cmd = {$urandom, 8'($urandom)};
      end
      stop();
      repeat ($urandom_range(0, 1)) tick();
      if (i % 97 == 50) begin
        #2 extReset_n = 1'b0;
        #4 extReset_n = 1'b1;
      end
    end
    cd_rand = 1'b0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
